// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   - 3-bit state encodings ST_IDLE..ST_STOP and the matching FSM enum
//   - CLKS_PER_BIT_DEF: default clk cycles per bit (100 MHz / 115200)
//   - tmr_w(): bit-timer counter width for a given CLKS_PER_BIT
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_st_e;

  localparam int CLKS_PER_BIT_DEF = 868;

  // Counter width able to hold CLKS_PER_BIT-1.
  function automatic int tmr_w(input int cpb);
    return (cpb < 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/uart_rx_nb_if.sv
// uart_rx_nb_if: CPU-side handshake of the UART receiver.
//   data_out   : last good received word (receiver -> consumer)
//   valid      : data_out holds an unacknowledged word
//   frame_err  : last frame had a bad stop bit
//   parity_err : last frame had a parity mismatch
//   overrun    : a completed frame was dropped while valid was high
//   ack        : consumer acknowledge (consumer -> receiver)
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_nb_if #(
  parameter int n = 8
);
  logic [n-1:0] data_out;
  logic         valid;
  logic         frame_err;
  logic         parity_err;
  logic         overrun;
  logic         ack;

  modport master (
    output data_out, valid, frame_err, parity_err, overrun,
    input  ack
  );

  modport slave (
    input  data_out, valid, frame_err, parity_err, overrun,
    output ack
  );
endinterface

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for the UART receiver.
// Ports:
//   clk     : system clock
//   clr     : synchronous active-high reset (counter -> 0)
//   restart : hold/force the counter to 0
//   half_tc : counter == CLKS_PER_BIT/2-1 (mid-start-bit point)
//   full_tc : counter == CLKS_PER_BIT-1; counter wraps to 0 on the next edge
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  output logic half_tc,
  output logic full_tc
);

  localparam int W = tmr_w(CLKS_PER_BIT);

  logic [W-1:0] cnt;

  assign half_tc = (cnt == W'(CLKS_PER_BIT / 2 - 1));
  assign full_tc = (cnt == W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (clr || restart || full_tc) cnt <= '0;
    else                           cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/uart_rx_nb.sv
// uart_rx_nb: n-bit asynchronous serial receiver (start + n data LSB first
// + [parity] + stop, idle-high line) with valid/ack handshake.
// Ports:
//   clk  : system clock, all logic on posedge
//   clr  : synchronous active-high reset, overrides everything
//   rx   : serial line, asynchronous to clk
//   bus  : uart_rx_nb_if.master (data_out, valid, frame_err, parity_err,
//          overrun out; ack in)
// Build option: define UART_RX_PARITY_EN to add one even-parity bit between
// the data bits and the stop bit; otherwise parity_err is tied to 0.
module uart_rx_nb
  import uart_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            rx,
  uart_rx_nb_if.master    bus
);

  localparam int IW = $clog2(n);

  // rx_p0/rx_s form the synchronizer; rx_prev is the edge-history flop.
  logic rx_p0, rx_s, rx_prev;
  logic fall;

  uart_st_e      st;
  logic [n-1:0]  shreg;
  logic [IW-1:0] idx;
  logic [n-1:0]  data_r;
  logic          valid_r, ferr_r, ovr_r;
  logic          ack_ok;
  logic          restart, half_tc, full_tc;
  logic          par_bad;
`ifdef UART_RX_PARITY_EN
  logic          perr_r;
`endif

  // ---- stage: input synchronizer / edge detect
  always_ff @(posedge clk) begin
    if (clr) begin
      rx_p0   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_s    <= rx_p0;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

  // Timer sits at 0 while idle so START counts from the edge itself, and
  // restarts at the mid-start point so DATA samples land mid-bit.
  assign restart = (st == S_IDLE) || ((st == S_START) && half_tc);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tmr (
    .clk     (clk),
    .clr     (clr),
    .restart (restart),
    .half_tc (half_tc),
    .full_tc (full_tc)
  );

  assign ack_ok = bus.ack & valid_r;

  // ---- stage: frame FSM, shift register and handshake
  always_ff @(posedge clk) begin
    if (clr) begin
      st      <= S_IDLE;
      shreg   <= '0;
      idx     <= '0;
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_r  <= 1'b0;
      par_bad <= 1'b0;
`endif
    end else begin
      // An accepted ack clears valid and the sticky overrun; a delivery on
      // the same edge below re-asserts valid.
      if (ack_ok) begin
        valid_r <= 1'b0;
        ovr_r   <= 1'b0;
      end

      unique case (st)
        S_IDLE: begin
          if (fall) st <= S_START;
        end

        S_START: begin
          if (half_tc) begin
            idx <= '0;
            // Line back high at mid-start: a glitch, not a frame.
            st  <= rx_s ? S_IDLE : S_DATA;
          end
        end

        S_DATA: begin
          if (full_tc) begin
            shreg <= {rx_s, shreg[n-1:1]};
            idx   <= idx + IW'(1);
            if (idx == IW'(n - 1)) begin
`ifdef UART_RX_PARITY_EN
              st <= S_PARITY;
`else
              st <= S_STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (full_tc) begin
            par_bad <= (^shreg) ^ rx_s;
            st      <= S_STOP;
          end
        end
`endif

        S_STOP: begin
          if (full_tc) begin
            st     <= S_IDLE;
            ferr_r <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_r <= par_bad;
`endif
            if (rx_s && !par_bad) begin
              if (!valid_r || bus.ack) begin
                data_r  <= shreg;
                valid_r <= 1'b1;
              end else begin
                ovr_r   <= 1'b1;
              end
            end
          end
        end

        default: st <= S_IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign par_bad = 1'b0;
`endif

  assign bus.data_out  = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = ferr_r;
  assign bus.overrun   = ovr_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
